// File: rtl/host_bus_arbiter.sv
// MAC host register bus arbiter: round-robin between requesters A and B, one host
// access plus a recovery cycle per grant, address range check and transaction counters.
module host_bus_arbiter #(
    parameter int unsigned ADDR_MAX = 34,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             i_clk_reg,
    input  logic             i_reset,
    input  logic             i_a_req,
    input  logic             i_a_we,
    input  logic [6:0]       i_a_addr,
    input  logic [15:0]      i_a_wdata,
    output logic             o_a_gnt,
    output logic             o_a_done,
    input  logic             i_b_req,
    input  logic             i_b_we,
    input  logic [6:0]       i_b_addr,
    input  logic [15:0]      i_b_wdata,
    output logic             o_b_gnt,
    output logic             o_b_done,
    output logic [15:0]      o_rsp_rdata,
    output logic             o_rsp_err,
    output logic             o_csb,
    output logic             o_wrb,
    output logic [7:0]       o_ca,
    output logic [15:0]      o_cd_in,
    input  logic [15:0]      i_cd_out,
    output logic [CNT_W-1:0] o_wr_cnt,
    output logic [CNT_W-1:0] o_rd_cnt
);

    typedef enum logic [1:0] {StIdle, StAccess, StReject, StRecover} state_e;

    localparam logic [6:0] AddrMaxL = 7'(ADDR_MAX);

    state_e             r_state;
    logic               r_last_b;
    logic               r_own_b;
    logic               r_we;
    logic               r_a_gnt, r_b_gnt, r_a_done, r_b_done;
    logic [15:0]        r_rsp_rdata;
    logic               r_rsp_err;
    logic               r_csb, r_wrb;
    logic [7:0]         r_ca;
    logic [15:0]        r_cd_in;
    logic [CNT_W-1:0]   r_wr_cnt, r_rd_cnt;

    logic               w_arb, w_pick_a, w_pick_b;
    logic               w_win_we, w_win_legal;
    logic [6:0]         w_win_addr;
    logic [15:0]        w_win_wdata;

    // On a tie the requester that was not granted last wins.
    always_comb begin
        w_arb       = (r_state == StIdle) || (r_state == StRecover);
        w_pick_a    = w_arb && i_a_req && (!i_b_req || r_last_b);
        w_pick_b    = w_arb && i_b_req && !w_pick_a;
        w_win_we    = w_pick_b ? i_b_we    : i_a_we;
        w_win_addr  = w_pick_b ? i_b_addr  : i_a_addr;
        w_win_wdata = w_pick_b ? i_b_wdata : i_a_wdata;
        w_win_legal = (w_win_addr <= AddrMaxL);
    end

    always_ff @(posedge i_clk_reg) begin
        if (i_reset) begin
            r_state     <= StIdle;
            r_last_b    <= 1'b1;
            r_own_b     <= 1'b0;
            r_we        <= 1'b0;
            r_a_gnt     <= 1'b0;
            r_b_gnt     <= 1'b0;
            r_a_done    <= 1'b0;
            r_b_done    <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_csb       <= 1'b1;
            r_wrb       <= 1'b1;
            r_ca        <= '0;
            r_cd_in     <= '0;
            r_wr_cnt    <= '0;
            r_rd_cnt    <= '0;
        end else begin
            r_a_gnt  <= 1'b0;
            r_b_gnt  <= 1'b0;
            r_a_done <= 1'b0;
            r_b_done <= 1'b0;
            r_csb    <= 1'b1;
            r_wrb    <= 1'b1;
            case (r_state)
                StAccess: begin
                    r_a_done  <= !r_own_b;
                    r_b_done  <= r_own_b;
                    r_rsp_err <= 1'b0;
                    if (r_we) begin
                        r_wr_cnt <= r_wr_cnt + CNT_W'(1);
                    end else begin
                        r_rd_cnt    <= r_rd_cnt + CNT_W'(1);
                        r_rsp_rdata <= i_cd_out;
                    end
                    r_state <= StRecover;
                end
                StReject: begin
                    r_a_done  <= !r_own_b;
                    r_b_done  <= r_own_b;
                    r_rsp_err <= 1'b1;
                    r_state   <= StRecover;
                end
                StIdle, StRecover: begin
                    if (w_pick_a || w_pick_b) begin
                        r_a_gnt  <= w_pick_a;
                        r_b_gnt  <= w_pick_b;
                        r_own_b  <= w_pick_b;
                        r_last_b <= w_pick_b;
                        r_we     <= w_win_we;
                        if (w_win_legal) begin
                            r_csb   <= 1'b0;
                            r_wrb   <= !w_win_we;
                            r_ca    <= {w_win_addr, 1'b0};
                            r_cd_in <= w_win_we ? w_win_wdata : 16'h0000;
                            r_state <= StAccess;
                        end else begin
                            r_state <= StReject;
                        end
                    end else begin
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_a_gnt     = r_a_gnt;
    assign o_b_gnt     = r_b_gnt;
    assign o_a_done    = r_a_done;
    assign o_b_done    = r_b_done;
    assign o_rsp_rdata = r_rsp_rdata;
    assign o_rsp_err   = r_rsp_err;
    assign o_csb       = r_csb;
    assign o_wrb       = r_wrb;
    assign o_ca        = r_ca;
    assign o_cd_in     = r_cd_in;
    assign o_wr_cnt    = r_wr_cnt;
    assign o_rd_cnt    = r_rd_cnt;

endmodule
